user_ram_rd_checker: RTL and testbench



---
 rtl/user_ram_chk_pkg.sv | 25 ++
 rtl/user_ram_rd_checker_if.sv | 12 +
 rtl/rd_lat_pipe.sv | 39 +++
 rtl/user_ram_rd_checker.sv | 148 ++++++++++++++
 tb/tb_user_ram_rd_checker.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/user_ram_chk_pkg.sv
// Shared types and the reference data pattern for the user-RAM read-back checker.
package user_ram_chk_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_INIT = 3'd1,
    ISSUE     = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } chk_state_e;

  // Pattern written by the counter-based writer, masked to the data width.
  function automatic logic [31:0] exp_data(input logic [31:0] addr,
                                           input logic [31:0] offset,
                                           input int unsigned width);
    logic [31:0] sum;
    sum = addr + offset;
    if (width >= 32'd32) begin
      return sum;
    end else begin
      return sum & ((32'd1 << width) - 32'd1);
    end
  endfunction

endpackage

// File: rtl/user_ram_rd_checker_if.sv
// User-side read port of the fabric RAM: strobe and address out, data back.
interface user_ram_rd_checker_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              rd_enable_user;
  logic [ADDR_W-1:0] raddr_user;
  logic [DATA_W-1:0] rdata_user;

  modport master (output rd_enable_user, output raddr_user, input rdata_user);
  modport slave  (input rd_enable_user, input raddr_user, output rdata_user);
endinterface

// File: rtl/rd_lat_pipe.sv
// Delay line of {valid, addr} matching the RAM read latency, so each returned
// word can be paired with the address that requested it.
module rd_lat_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 6
) (
  input  logic              Clock,
  input  logic              Aclr,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              any_vld_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o     = vld_q[DEPTH-1];
  assign addr_o    = addr_q[DEPTH-1];
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/user_ram_rd_checker.sv
// Sweeps every user-RAM address once, checks each returned word against the
// writer's address+offset pattern and keeps pass/fail, error count and first miss.
module user_ram_rd_checker
  import user_ram_chk_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int RD_LAT      = 1,
  parameter int DATA_OFFSET = 0,
  parameter int ERR_W       = 8
) (
  input  logic                  Clock,
  input  logic                  Aclr,
  user_ram_rd_checker_if.master ram,
  input  logic                  start,
  input  logic                  ram_init_done,
  input  logic                  ahb_busy,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [DATA_W-1:0]     first_err_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  chk_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] ferr_addr_q;
  logic [DATA_W-1:0] ferr_data_q;

  logic              chk_vld;
  logic [ADDR_W-1:0] chk_addr;
  logic              pipe_any;
  logic              mismatch;

  // Pipe is fed from the registered strobe so it lines up with what the RAM saw.
  rd_lat_pipe #(
    .DEPTH  (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .Clock     (Clock),
    .Aclr      (Aclr),
    .vld_i     (rd_en_q),
    .addr_i    (raddr_q),
    .vld_o     (chk_vld),
    .addr_o    (chk_addr),
    .any_vld_o (pipe_any)
  );

  assign mismatch = chk_vld &&
                    (32'(ram.rdata_user) != exp_data(32'(chk_addr), 32'(DATA_OFFSET), DATA_W));

  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      raddr_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      // A zero count means no miss yet this sweep, since the count never wraps.
      if (mismatch) begin
        if (err_q != '1) begin
          err_q <= err_q + ERR_W'(1);
        end
        if (err_q == '0) begin
          ferr_addr_q <= chk_addr;
          ferr_data_q <= ram.rdata_user;
        end
      end

      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          if (start) begin
            state_q     <= WAIT_INIT;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            addr_q      <= '0;
          end
        end
        WAIT_INIT: begin
          rd_en_q <= 1'b0;
          if (ram_init_done) begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!ahb_busy) begin
            rd_en_q <= 1'b1;
            raddr_q <= addr_q;
            addr_q  <= addr_q + ADDR_W'(1);
            if (addr_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          rd_en_q <= 1'b0;
          // The final strobe is still in rd_en_q on the first drain cycle.
          if (!rd_en_q && !pipe_any) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0);
          state_q <= IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ram.rd_enable_user = rd_en_q;
  assign ram.raddr_user     = raddr_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign err_count          = err_q;
  assign first_err_addr     = ferr_addr_q;
  assign first_err_data     = ferr_data_q;

endmodule

// File: tb/tb_user_ram_rd_checker.sv
// Scoreboard bench: two checker instances (RD_LAT=1/ERR_W=8 and RD_LAT=3/ERR_W=4)
// against behavioural RAM models with selectable corruption.
module tb_user_ram_rd_checker;

  typedef struct {
    logic [7:0] err;
    logic [5:0] fa;
    logic [7:0] fd;
    logic       pass;
  } res_t;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] init = 2'b00;
  logic [1:0] stall = 2'b00;
  logic [1:0] stall_prev = 2'b00;
  int         mode [2] = '{0, 0};

  logic [1:0] busy_w, done_w, pass_w;
  logic [7:0] err_a, fd_a, fd_b;
  logic [3:0] err_b;
  logic [5:0] fa_a, fa_b;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_strobe [2] = '{0, 0};
  int   first_cyc [2] = '{0, 0};
  int   last_cyc [2] = '{0, 0};
  logic [5:0] qa [$];
  logic [5:0] qb [$];
  res_t res_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  user_ram_rd_checker_if #(.ADDR_W(6), .DATA_W(8)) ram_a ();
  user_ram_rd_checker_if #(.ADDR_W(6), .DATA_W(8)) ram_b ();

  user_ram_rd_checker #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .DATA_OFFSET(0), .ERR_W(8)) dut_a (
    .Clock(clk), .Aclr(rst[0]), .ram(ram_a), .start(start[0]), .ram_init_done(init[0]),
    .ahb_busy(stall[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_a), .first_err_addr(fa_a), .first_err_data(fd_a));

  user_ram_rd_checker #(.ADDR_W(6), .DATA_W(8), .RD_LAT(3), .DATA_OFFSET(0), .ERR_W(4)) dut_b (
    .Clock(clk), .Aclr(rst[1]), .ram(ram_b), .start(start[1]), .ram_init_done(init[1]),
    .ahb_busy(stall[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_b), .first_err_addr(fa_b), .first_err_data(fd_b));

  // RAM content: mode 0 clean, 1 two corrupted words, 2 all zero.
  function automatic logic [7:0] model(input int m, input logic [5:0] a);
    if (m == 2) return 8'h00;
    if (m == 1 && a == 6'h15) return 8'hFF;
    if (m == 1 && a == 6'h30) return 8'h00;
    return {2'b00, a};
  endfunction

  logic [7:0] pa;
  logic [7:0] pb [3];
  always @(posedge clk) pa <= ram_a.rd_enable_user ? model(mode[0], ram_a.raddr_user) : 8'hA5;
  always @(posedge clk) begin
    pb[0] <= ram_b.rd_enable_user ? model(mode[1], ram_b.raddr_user) : 8'hA5;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign ram_a.rdata_user = pa;
  assign ram_b.rdata_user = pb[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic strobe_seen(input int w, input logic [5:0] a);
    int sz;
    chk("no_strobe_after_stall", stall_prev[w], 1'b0);
    sz = (w == 0) ? qa.size() : qb.size();
    chk("strobe_expected", sz != 0, 1'b1);
    if (sz != 0) begin
      if (w == 0) chk("raddr_a", a, qa.pop_front());
      else        chk("raddr_b", a, qb.pop_front());
    end
    n_strobe[w]++;
    if (n_strobe[w] == 1) first_cyc[w] = cyc;
    last_cyc[w] = cyc;
  endtask

  always @(negedge clk) begin
    if (ram_a.rd_enable_user) strobe_seen(0, ram_a.raddr_user);
    if (ram_b.rd_enable_user) strobe_seen(1, ram_b.raddr_user);
    stall_prev <= stall;
  end

  task automatic check_zero(input int w);
    chk("zero_rd_en", (w == 0) ? ram_a.rd_enable_user : ram_b.rd_enable_user, 1'b0);
    chk("zero_raddr", (w == 0) ? ram_a.raddr_user : ram_b.raddr_user, 6'h00);
    chk("zero_busy", busy_w[w], 1'b0);
    chk("zero_done", done_w[w], 1'b0);
    chk("zero_pass", pass_w[w], 1'b0);
    chk("zero_err", (w == 0) ? err_a : {4'h0, err_b}, 8'h00);
    chk("zero_faddr", (w == 0) ? fa_a : fa_b, 6'h00);
    chk("zero_fdata", (w == 0) ? fd_a : fd_b, 8'h00);
  endtask

  task automatic sweep(input int w, input int init_delay, input int stall_after, input bit spam,
                       input logic [7:0] e_err, input logic [5:0] e_fa, input logic [7:0] e_fd,
                       input logic e_pass);
    res_t r;
    int   init_cyc;
    int   stalled;
    bit   seen;
    init_cyc = 0;
    stalled  = 0;
    seen     = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (w == 0) qa.push_back(6'(i));
      else        qb.push_back(6'(i));
    end
    r.err = e_err; r.fa = e_fa; r.fd = e_fd; r.pass = e_pass;
    res_q.push_back(r);
    n_strobe[w] = 0;
    if (init_delay >= 0) init[w] = 1'b0;
    @(posedge clk); #1 start[w] = 1'b1;
    @(posedge clk); #1 start[w] = 1'b0;
    chk("busy_after_start", busy_w[w], 1'b1);
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (init_delay >= 0 && k == init_delay) begin
        init[w]  = 1'b1;
        init_cyc = cyc;
      end
      if (stall_after >= 0) begin
        if (n_strobe[w] >= stall_after && stalled < 5) begin
          stall[w] = 1'b1;
          stalled++;
        end else begin
          stall[w] = 1'b0;
        end
      end
      start[w] = spam && busy_w[w] && (k % 7 == 3);
      if (done_w[w]) begin
        seen = 1'b1;
        break;
      end
    end
    start[w] = 1'b0;
    chk("done_seen", seen, 1'b1);
    r = res_q.pop_front();
    chk("err_count", (w == 0) ? err_a : {4'h0, err_b}, r.err);
    chk("first_err_addr", (w == 0) ? fa_a : fa_b, r.fa);
    chk("first_err_data", (w == 0) ? fd_a : fd_b, r.fd);
    chk("pass", pass_w[w], r.pass);
    chk("busy_at_done", busy_w[w], 1'b0);
    chk("strobes_left", (w == 0) ? qa.size() : qb.size(), 0);
    chk("strobe_count", n_strobe[w], 64);
    if (stall_after < 0) chk("strobe_span", last_cyc[w] - first_cyc[w], 63);
    if (init_delay >= 0) chk("first_strobe_lat", first_cyc[w] - init_cyc, 2);
    if (spam) begin
      repeat (6) @(posedge clk);
      #1;
      chk("done_held", done_w[w], 1'b1);
      chk("stays_idle", busy_w[w], 1'b0);
    end
  endtask

  task automatic abort_sweep();
    qa.delete();
    for (int i = 0; i <= 32; i++) qa.push_back(6'(i));
    n_strobe[0] = 0;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    for (int k = 0; k < 500 && n_strobe[0] < 33; k++) begin
      @(posedge clk); #1;
    end
    rst[0] = 1'b1;
    #1;
    check_zero(0);
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy_w[0], 1'b0);
    chk("abort_idle_done", done_w[0], 1'b0);
    chk("abort_strobes_left", qa.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    rst  = 2'b00;
    init = 2'b11;
    repeat (2) @(posedge clk);

    mode[0] = 0;
    sweep(0, -1, -1, 1'b0, 8'd0, 6'h00, 8'h00, 1'b1);
    mode[0] = 1;
    sweep(0, -1, -1, 1'b0, 8'd2, 6'h15, 8'hFF, 1'b0);
    mode[1] = 0;
    sweep(1, -1, 20, 1'b0, 8'd0, 6'h00, 8'h00, 1'b1);
    mode[0] = 0;
    sweep(0, 20, -1, 1'b0, 8'd0, 6'h00, 8'h00, 1'b1);
    abort_sweep();
    sweep(0, -1, -1, 1'b0, 8'd0, 6'h00, 8'h00, 1'b1);
    mode[1] = 2;
    sweep(1, -1, -1, 1'b1, 8'h0F, 6'h01, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
